// File: rtl/calc_n_pkg.sv
// Shared command/response codes, queue-entry and response payloads, and the ALU function.
// Optional feature macro: CALC_ROT_EN (enables rotate-left cmd 7 / rotate-right cmd 8).
package calc_n_pkg;

  localparam int unsigned CALC_DATA_W = 32;
  localparam int unsigned CALC_TAG_W  = 2;
  localparam int unsigned CMD_W       = 4;
  localparam int unsigned RESP_W      = 2;
  localparam int unsigned SHAMT_W     = $clog2(CALC_DATA_W);

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;
  localparam logic [CMD_W-1:0] CMD_ROL = 4'd7;
  localparam logic [CMD_W-1:0] CMD_ROR = 4'd8;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

  typedef struct packed {
    logic [CMD_W-1:0]       cmd;
    logic [CALC_TAG_W-1:0]  tag;
    logic [CALC_DATA_W-1:0] op1;
    logic [CALC_DATA_W-1:0] op2;
  } calc_entry_t;

  typedef struct packed {
    logic [RESP_W-1:0]      resp;
    logic [CALC_TAG_W-1:0]  tag;
    logic [CALC_DATA_W-1:0] data;
  } calc_resp_t;

  // Unsigned arithmetic on one queue entry; any error leaves data at zero.
  function automatic calc_resp_t calc_alu(input calc_entry_t e);
    calc_resp_t               r;
    logic [CALC_DATA_W:0]     wide;
    logic [SHAMT_W-1:0]       amt;
`ifdef CALC_ROT_EN
    logic [2*CALC_DATA_W-1:0] dbl;
`endif
    r.resp = RESP_ERR;
    r.tag  = e.tag;
    r.data = '0;
    wide   = '0;
    amt    = e.op2[SHAMT_W-1:0];
`ifdef CALC_ROT_EN
    dbl    = '0;
`endif
    case (e.cmd)
      CMD_ADD: begin
        wide = {1'b0, e.op1} + {1'b0, e.op2};
        if (!wide[CALC_DATA_W]) begin
          r.resp = RESP_OK;
          r.data = wide[CALC_DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (e.op2 <= e.op1) begin
          r.resp = RESP_OK;
          r.data = e.op1 - e.op2;
        end
      end
      CMD_SHL: begin
        r.resp = RESP_OK;
        r.data = e.op1 << amt;
      end
      CMD_SHR: begin
        r.resp = RESP_OK;
        r.data = e.op1 >> amt;
      end
`ifdef CALC_ROT_EN
      CMD_ROL: begin
        dbl    = {e.op1, e.op1} << amt;
        r.resp = RESP_OK;
        r.data = dbl[2*CALC_DATA_W-1:CALC_DATA_W];
      end
      CMD_ROR: begin
        dbl    = {e.op1, e.op1} >> amt;
        r.resp = RESP_OK;
        r.data = dbl[CALC_DATA_W-1:0];
      end
`endif
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_n_if.sv
// Requester/response bus of the calculator: flat per-port request beats and tagged responses.
interface calc_n_if #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 2
);
  import calc_n_pkg::*;

  logic [NPORTS*CMD_W-1:0]  req_cmd_in;
  logic [NPORTS*TAG_W-1:0]  req_tag_in;
  logic [NPORTS*DATA_W-1:0] req_data_in;
  logic [NPORTS-1:0]        req_ready;
  logic [NPORTS*RESP_W-1:0] out_resp;
  logic [NPORTS*TAG_W-1:0]  out_tag;
  logic [NPORTS*DATA_W-1:0] out_data;

  modport master (
    output req_cmd_in, req_tag_in, req_data_in,
    input  req_ready, out_resp, out_tag, out_data
  );

  modport slave (
    input  req_cmd_in, req_tag_in, req_data_in,
    output req_ready, out_resp, out_tag, out_data
  );

endinterface

// File: rtl/calc_n_port_queue.sv
// One requester port: two-beat capture FSM feeding a DEPTH-entry command FIFO.
module calc_n_port_queue
  import calc_n_pkg::*;
#(
  parameter int unsigned DATA_W = CALC_DATA_W,
  parameter int unsigned TAG_W  = CALC_TAG_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  input  logic              pop,
  output logic              head_valid_c,
  output calc_entry_t       head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OP2  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CMD_W-1:0]  hold_cmd_q, hold_cmd_d;
  logic [TAG_W-1:0]  hold_tag_q, hold_tag_d;
  logic [DATA_W-1:0] hold_op1_q, hold_op1_d;
  logic              push;
  logic              pop_ok;
  calc_entry_t       push_entry;
  calc_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;

  // Capture state register.
  always_ff @(posedge c_clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Capture FSM: accept cmd beat when ready, push the full entry on the operand-2 beat.
  always_comb begin
    state_d    = state_q;
    hold_cmd_d = hold_cmd_q;
    hold_tag_d = hold_tag_q;
    hold_op1_d = hold_op1_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready_q && (cmd != CMD_NOP)) begin
          state_d    = ST_OP2;
          hold_cmd_d = cmd;
          hold_tag_d = tag;
          hold_op1_d = data;
        end
      end
      ST_OP2: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // First-beat holding registers.
  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      hold_cmd_q <= '0;
      hold_tag_q <= '0;
      hold_op1_q <= '0;
    end else begin
      hold_cmd_q <= hold_cmd_d;
      hold_tag_q <= hold_tag_d;
      hold_op1_q <= hold_op1_d;
    end
  end

  // Occupancy and next-cycle ready; ready only while idle with a free slot.
  always_comb begin
    push_entry.cmd = hold_cmd_q;
    push_entry.tag = hold_tag_q;
    push_entry.op1 = hold_op1_q;
    push_entry.op2 = data;
    pop_ok         = pop && (count_q != '0);
    count_d        = count_q;
    if (push && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!push && pop_ok) count_d = count_q - CNT_W'(1);
    ready_d = (state_d == ST_IDLE) && (count_d < CNT_W'(DEPTH));
  end

  // FIFO pointers, count and registered ready; pointers wrap naturally mod DEPTH.
  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // FIFO storage; contents are don't-care until the pointers make them visible.
  always_ff @(posedge c_clk) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  assign ready        = ready_q;
  assign head_valid_c = (count_q != '0);
  assign head_c       = mem[rd_ptr_q];

endmodule

// File: rtl/calc_n.sv
// Multi-port calculator: per-port queues, round-robin arbiter, 2-stage ALU, per-port response registers.
// Optional feature macro: CALC_ROT_EN (rotate commands, handled inside calc_n_pkg::calc_alu).
module calc_n
  import calc_n_pkg::*;
#(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DATA_W = CALC_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = CALC_TAG_W
) (
  input logic     c_clk,
  input logic     reset_n,
  calc_n_if.slave bus
);

  localparam int unsigned PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [NPORTS-1:0]        ready_vec;
  logic [NPORTS-1:0]        head_valid;
  logic [NPORTS-1:0]        pop;
  calc_entry_t              head [NPORTS];

  logic                     grant_valid;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  int unsigned              idx;

  logic                     s1_valid_q;
  logic [PTR_W-1:0]         s1_port_q;
  calc_entry_t              s1_entry_q;
  calc_resp_t               alu_res;

  logic [NPORTS*RESP_W-1:0] resp_q;
  logic [NPORTS*TAG_W-1:0]  tag_q;
  logic [NPORTS*DATA_W-1:0] data_q;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    calc_n_port_queue #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .DEPTH  (DEPTH)
    ) u_queue (
      .c_clk        (c_clk),
      .reset_n      (reset_n),
      .cmd          (bus.req_cmd_in[p*CMD_W +: CMD_W]),
      .tag          (bus.req_tag_in[p*TAG_W +: TAG_W]),
      .data         (bus.req_data_in[p*DATA_W +: DATA_W]),
      .ready        (ready_vec[p]),
      .pop          (pop[p]),
      .head_valid_c (head_valid[p]),
      .head_c       (head[p])
    );
  end

  // Round-robin grant: first non-empty queue at or after the pointer.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    pop         = '0;
    ptr_d       = ptr_q;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!grant_valid && head_valid[PTR_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
      ptr_d = (32'(grant_idx) == NPORTS - 1) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Arbiter pointer and ALU stage 1 (granted entry and its port).
  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_port_q  <= '0;
      s1_entry_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= grant_valid;
      s1_port_q  <= grant_idx;
      s1_entry_q <= head[grant_idx];
    end
  end

  // ALU stage 2 arithmetic.
  always_comb begin
    alu_res = calc_alu(s1_entry_q);
  end

  // Response demux: only the issuing port sees the result, all others read zero.
  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      resp_q <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (s1_valid_q && (s1_port_q == PTR_W'(p))) begin
          resp_q[p*RESP_W +: RESP_W] <= alu_res.resp;
          tag_q[p*TAG_W +: TAG_W]    <= alu_res.tag;
          data_q[p*DATA_W +: DATA_W] <= alu_res.data;
        end else begin
          resp_q[p*RESP_W +: RESP_W] <= RESP_NONE;
          tag_q[p*TAG_W +: TAG_W]    <= '0;
          data_q[p*DATA_W +: DATA_W] <= '0;
        end
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.out_resp  = resp_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_calc_n.sv
// Directed bench for calc_n: latency, arithmetic edges, arbitration order, back-pressure, reset abort.
module tb_calc_n;
  import calc_n_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 2;
  localparam int unsigned QD = 4;

  logic c_clk   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 c_clk = ~c_clk;

  calc_n_if #(.NPORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

  calc_n #(.NPORTS(NP), .DATA_W(DW), .DEPTH(QD), .TAG_W(TW)) dut (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq [NP][$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [3:0] cmd, input logic [TW-1:0] tag,
                       input logic [DW-1:0] d);
    bus.req_cmd_in[p*4 +: 4]    = cmd;
    bus.req_tag_in[p*TW +: TW]  = tag;
    bus.req_data_in[p*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    bus.req_cmd_in  = '0;
    bus.req_tag_in  = '0;
    bus.req_data_in = '0;
  endtask

  function automatic logic [1:0] resp_of(input int p);
    return bus.out_resp[p*2 +: 2];
  endfunction

  function automatic logic [TW-1:0] tag_of(input int p);
    return bus.out_tag[p*TW +: TW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int p);
    return bus.out_data[p*DW +: DW];
  endfunction

  // One uncontended request; response must appear exactly in cycle t+3 for one cycle.
  task automatic op_test(input string name, input int p, input logic [3:0] cmd,
                         input logic [TW-1:0] tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] eresp, input logic [DW-1:0] edata);
    chk({name, "_ready"}, 64'(bus.req_ready[p]), 64'd1);
    drive(p, cmd, tag, a);
    tick();
    drive(p, 4'd0, '0, b);
    tick();
    drive(p, 4'd0, '0, '0);
    tick();
    chk({name, "_early"}, 64'(resp_of(p)), 64'd0);
    tick();
    chk({name, "_resp"}, 64'(resp_of(p)), 64'(eresp));
    chk({name, "_tag"}, 64'(tag_of(p)), 64'(tag));
    chk({name, "_data"}, 64'(data_of(p)), 64'(edata));
    tick();
    chk({name, "_after"}, 64'(resp_of(p)), 64'd0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int            phase [NP];
    logic [DW-1:0] pa [NP];
    logic [DW-1:0] pb [NP];
    logic [TW-1:0] ntag [NP];
    int            dropped [NP];
    int            accepted;
    int            rcvd;
    int            quiet;
    bit            idle_all;
    logic [DW-1:0] a;
    exp_t          e;

    // Reset state
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp", 64'(bus.out_resp), 64'd0);
    chk("rst_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_data", 64'(|bus.out_data), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_ready_rel", 64'(bus.req_ready), 64'hF);
    chk("rst_resp_rel", 64'(bus.out_resp), 64'd0);

    // All ports add k+k together: served 0,1,2,3 on consecutive cycles
    for (int p = 0; p < int'(NP); p++) drive(p, CMD_ADD, TW'(p), DW'(p));
    tick();
    for (int p = 0; p < int'(NP); p++) drive(p, 4'd0, '0, DW'(p));
    tick();
    clear_inputs();
    tick();
    chk("sim_early", 64'(bus.out_resp), 64'd0);
    for (int j = 0; j < int'(NP); j++) begin
      tick();
      for (int p = 0; p < int'(NP); p++) begin
        chk($sformatf("sim_resp_c%0d_p%0d", j, p), 64'(resp_of(p)), (p == j) ? 64'd1 : 64'd0);
        chk($sformatf("sim_data_c%0d_p%0d", j, p), 64'(data_of(p)), (p == j) ? 64'(2 * j) : 64'd0);
        chk($sformatf("sim_tag_c%0d_p%0d", j, p), 64'(tag_of(p)), (p == j) ? 64'(j) : 64'd0);
      end
    end
    tick();
    chk("sim_after", 64'(bus.out_resp), 64'd0);

    // Basic add and arithmetic edges
    op_test("add_basic", 0, CMD_ADD, 2'd2, 32'h0000_0001, 32'h1FFF_FFFF, RESP_OK, 32'h2000_0000);
    op_test("add_ovf", 0, CMD_ADD, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, RESP_ERR, 32'h0);
    op_test("add_max", 0, CMD_ADD, 2'd3, 32'hFFFF_FFFE, 32'h0000_0001, RESP_OK, 32'hFFFF_FFFF);
    op_test("sub_udf", 0, CMD_SUB, 2'd0, 32'h0000_0001, 32'h0000_000F, RESP_ERR, 32'h0);
    op_test("sub_ok", 0, CMD_SUB, 2'd1, 32'h0000_000F, 32'h0000_0001, RESP_OK, 32'h0000_000E);
    op_test("sub_eq", 3, CMD_SUB, 2'd2, 32'h0000_0005, 32'h0000_0005, RESP_OK, 32'h0);
    op_test("bad_cmd3", 1, 4'd3, 2'd3, 32'h1234_5678, 32'h1, RESP_ERR, 32'h0);
    op_test("bad_cmd15", 1, 4'd15, 2'd0, 32'h1234_5678, 32'h1, RESP_ERR, 32'h0);

    // Shifts
    op_test("shl31", 2, CMD_SHL, 2'd1, 32'h0000_0001, 32'd31, RESP_OK, 32'h8000_0000);
    op_test("shr4", 2, CMD_SHR, 2'd2, 32'h8000_0000, 32'd4, RESP_OK, 32'h0800_0000);
    op_test("shl32", 2, CMD_SHL, 2'd3, 32'h0000_1234, 32'd32, RESP_OK, 32'h0000_1234);

    // Back-to-back on all ports with back-pressure, scoreboarded per port
    for (int p = 0; p < int'(NP); p++) begin
      phase[p]   = 0;
      pa[p]      = '0;
      pb[p]      = '0;
      ntag[p]    = '0;
      dropped[p] = 0;
    end
    accepted = 0;
    rcvd     = 0;
    quiet    = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < int'(NP); p++) begin
        if (resp_of(p) != 2'd0) begin
          rcvd++;
          if (sbq[p].size() == 0) begin
            chk($sformatf("bb_extra_p%0d", p), 64'(resp_of(p)), 64'd0);
          end else begin
            e = sbq[p].pop_front();
            chk($sformatf("bb_resp_p%0d", p), 64'(resp_of(p)), 64'd1);
            chk($sformatf("bb_tag_p%0d", p), 64'(tag_of(p)), 64'(e.tag));
            chk($sformatf("bb_data_p%0d", p), 64'(data_of(p)), 64'(e.data));
          end
        end
      end
      idle_all = (cyc >= 40);
      for (int p = 0; p < int'(NP); p++) begin
        if (phase[p] != 0 || sbq[p].size() != 0) idle_all = 1'b0;
      end
      if (idle_all) begin
        quiet++;
        if (quiet > 6) break;
      end
      for (int p = 0; p < int'(NP); p++) begin
        if (phase[p] == 1) begin
          drive(p, 4'd0, '0, pb[p]);
          phase[p] = 0;
        end else if (cyc < 40) begin
          a = DW'(p * 1000 + cyc * 7);
          drive(p, CMD_ADD, ntag[p], a);
          if (bus.req_ready[p]) begin
            pa[p] = a;
            pb[p] = DW'(cyc + 1);
            sbq[p].push_back('{tag: ntag[p], data: pa[p] + pb[p]});
            ntag[p]  = ntag[p] + TW'(1);
            phase[p] = 1;
            accepted++;
          end else begin
            dropped[p]++;
          end
        end else begin
          drive(p, 4'd0, '0, '0);
        end
      end
      tick();
    end
    clear_inputs();
    for (int p = 0; p < int'(NP); p++) begin
      chk($sformatf("bb_left_p%0d", p), 64'(sbq[p].size()), 64'd0);
      chk($sformatf("bb_backpressure_p%0d", p), 64'(dropped[p] > 0), 64'd1);
    end
    chk("bb_count", 64'(rcvd), 64'(accepted));

    // Reset with three commands queued: nothing must ever come out
    for (int p = 0; p < 3; p++) drive(p, CMD_ADD, TW'(p), 32'h10);
    tick();
    for (int p = 0; p < 3; p++) drive(p, 4'd0, '0, 32'h20);
    tick();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_resp", 64'(bus.out_resp), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("mid_rel_ready", 64'(bus.req_ready), 64'hF);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("mid_quiet_resp_%0d", c), 64'(bus.out_resp), 64'd0);
      chk($sformatf("mid_quiet_data_%0d", c), 64'(|bus.out_data), 64'd0);
      tick();
    end

    // Rotate commands
`ifdef CALC_ROT_EN
    op_test("rol1", 1, CMD_ROL, 2'd1, 32'h8000_0001, 32'd1, RESP_OK, 32'h0000_0003);
    op_test("ror1", 1, CMD_ROR, 2'd2, 32'h8000_0001, 32'd1, RESP_OK, 32'hC000_0000);
`else
    op_test("rol1", 1, CMD_ROL, 2'd1, 32'h8000_0001, 32'd1, RESP_ERR, 32'h0);
    op_test("ror1", 1, CMD_ROR, 2'd2, 32'h8000_0001, 32'd1, RESP_ERR, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
